sprite_palette_engine: RTL and testbench

Parametrised, runtime-writable, multi-bank colour lookup for sprite pixels. It maps a per-pixel colour index plus a bank (character/costume) select to 12-bit RGB through a two-stage pipeline. It also flags the transparency key colour and applies a frame-timed hit-flash effect that forces opaque pixels to white. It sits between the sprite ROM/address logic and the VGA colour mux, and replaces the fixed per-sprite palette modules.

---
 rtl/sprite_palette_engine.sv | 148 ++++++++++++++
 tb/tb_sprite_palette_engine.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_palette_engine.sv
// sprite_palette_engine
//   Runtime-writable, multi-bank colour lookup for sprite pixels. A colour
//   index plus a bank select is turned into {red, green, blue} through a
//   two-stage pipeline. The engine also flags the transparency key colour and
//   runs a frame-timed hit flash that forces opaque pixels to white.
//
// Ports
//   Clk, Reset_n       : clock (rising edge), asynchronous active-low reset
//   wr_en/wr_bank/wr_index/wr_rgb : palette entry write port
//   pix_valid/pix_bank/pix_index  : lookup request, one pixel per cycle
//   frame_tick         : one-cycle pulse per video frame
//   flash_start        : one-cycle pulse that starts or restarts the flash
//   out_valid          : result valid, two cycles after pix_valid
//   red/green/blue     : output colour, held while out_valid is low
//   transparent        : looked-up entry equals KEY
//   flash_active       : flash sequence in progress
module sprite_palette_engine #(
  parameter int IDX_W        = 4,
  parameter int BANKS        = 4,
  parameter int CH_W         = 4,
  parameter logic [3*CH_W-1:0] KEY = {{CH_W{1'b1}}, {CH_W{1'b0}}, {CH_W{1'b1}}},
  parameter int FLASH_FRAMES = 3,
  parameter int FLASH_PHASES = 6,
  localparam int BANK_W      = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [3*CH_W-1:0] wr_rgb,
  input  logic              pix_valid,
  input  logic [BANK_W-1:0] pix_bank,
  input  logic [IDX_W-1:0]  pix_index,
  input  logic              frame_tick,
  input  logic              flash_start,
  output logic              out_valid,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              transparent,
  output logic              flash_active
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int RGB_W   = 3 * CH_W;
  localparam int FF_W    = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int PH_W    = (FLASH_PHASES > 1) ? $clog2(FLASH_PHASES) : 1;

  // One extra bit so a bank count that is a power of two still compares cleanly.
  localparam logic [BANK_W:0] BANK_LIMIT  = (BANK_W+1)'(BANKS);
  localparam logic [FF_W-1:0] FRAME_LAST  = FF_W'(FLASH_FRAMES - 1);
  localparam logic [PH_W-1:0] PHASE_LAST  = PH_W'(FLASH_PHASES - 1);

  typedef enum logic [1:0] {IDLE, ON, OFF} flash_state_t;

  logic [RGB_W-1:0] mem [BANKS][ENTRIES];
  logic             wr_ok;
  logic             rd_ok;
  logic [RGB_W-1:0] rd_raw;

  logic             s1_valid;
  logic [RGB_W-1:0] s1_raw;
  logic [RGB_W-1:0] colour;

  flash_state_t     state;
  logic [FF_W-1:0]  frame_cnt;
  logic [PH_W-1:0]  phase_cnt;

  assign wr_ok  = wr_en && ({1'b0, wr_bank} < BANK_LIMIT);
  assign rd_ok  = ({1'b0, pix_bank} < BANK_LIMIT);
  // Out-of-range banks read as the key colour, so they show up transparent.
  assign rd_raw = rd_ok ? mem[pix_bank][pix_index] : KEY;

  // Palette storage. Reads above use the pre-edge contents, so a write and a
  // read of the same entry in one cycle returns the old colour.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int b = 0; b < BANKS; b++)
        for (int i = 0; i < ENTRIES; i++)
          mem[b][i] <= KEY;
    end else if (wr_ok) begin
      mem[wr_bank][wr_index] <= wr_rgb;
    end
  end

  // Stage 1: capture the raw entry.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid <= 1'b0;
      s1_raw   <= '0;
    end else begin
      s1_valid <= pix_valid;
      if (pix_valid)
        s1_raw <= rd_raw;
    end
  end

  // Stage 2: key detect and flash override, using the flash state current at
  // this edge. Colour and transparency hold when no pixel is in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid   <= 1'b0;
      transparent <= 1'b0;
      colour      <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        transparent <= (s1_raw == KEY);
        colour      <= (state == ON && s1_raw != KEY) ? '1 : s1_raw;
      end
    end
  end

  // Hit-flash sequencer. flash_start always wins over a coincident frame_tick.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      frame_cnt    <= '0;
      phase_cnt    <= '0;
      flash_active <= 1'b0;
    end else if (flash_start) begin
      state        <= ON;
      frame_cnt    <= '0;
      phase_cnt    <= '0;
      flash_active <= 1'b1;
    end else if (state != IDLE && frame_tick) begin
      if (frame_cnt != FRAME_LAST) begin
        frame_cnt <= frame_cnt + FF_W'(1);
      end else begin
        frame_cnt <= '0;
        if (phase_cnt == PHASE_LAST) begin
          state        <= IDLE;
          phase_cnt    <= '0;
          flash_active <= 1'b0;
        end else begin
          phase_cnt <= phase_cnt + PH_W'(1);
          state     <= (state == ON) ? OFF : ON;
        end
      end
    end
  end

  assign red   = colour[RGB_W-1 -: CH_W];
  assign green = colour[2*CH_W-1 -: CH_W];
  assign blue  = colour[CH_W-1:0];

endmodule

// File: tb/tb_sprite_palette_engine.sv
// tb_sprite_palette_engine
//   Directed bench for sprite_palette_engine built with BANKS=3 so that bank 3
//   is out of range. Inputs change on the falling clock edge and outputs are
//   sampled there too, well away from the rising edge.
module tb_sprite_palette_engine;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_bank = '0;
  logic [3:0]  wr_index = '0;
  logic [11:0] wr_rgb = '0;
  logic        pix_valid = 1'b0;
  logic [1:0]  pix_bank = '0;
  logic [3:0]  pix_index = '0;
  logic        frame_tick = 1'b0;
  logic        flash_start = 1'b0;
  logic        out_valid;
  logic [3:0]  red, green, blue;
  logic        transparent;
  logic        flash_active;

  int checks = 0;
  int fails  = 0;

  logic        mid_v, v, tr;
  logic [11:0] rgb;

  sprite_palette_engine #(.BANKS(3)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index), .wr_rgb(wr_rgb),
    .pix_valid(pix_valid), .pix_bank(pix_bank), .pix_index(pix_index),
    .frame_tick(frame_tick), .flash_start(flash_start),
    .out_valid(out_valid), .red(red), .green(green), .blue(blue),
    .transparent(transparent), .flash_active(flash_active)
  );

  always #5 Clk = ~Clk;

  task automatic cyc();
    @(negedge Clk);
  endtask

  task automatic do_write(input logic [1:0] bank, input logic [3:0] idx, input logic [11:0] val);
    wr_en = 1'b1; wr_bank = bank; wr_index = idx; wr_rgb = val;
    cyc();
    wr_en = 1'b0;
  endtask

  // Issues one pixel and returns out_valid after one edge and the full result after two.
  task automatic read_pixel(input logic [1:0] bank, input logic [3:0] idx,
                            output logic m_v, output logic r_v,
                            output logic [11:0] r_rgb, output logic r_tr);
    pix_valid = 1'b1; pix_bank = bank; pix_index = idx;
    cyc();
    pix_valid = 1'b0;
    m_v = out_valid;
    cyc();
    r_v = out_valid; r_rgb = {red, green, blue}; r_tr = transparent;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    pix_valid = 1'b1; pix_bank = 2'd0; pix_index = 4'd5;
    repeat (3) cyc();
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if ({red, green, blue} !== 12'h000) begin fails++; $display("[TB] FAIL reset_rgb: got %h expected 000", {red, green, blue}); end
    checks++;
    if (transparent !== 1'b0 || flash_active !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_flags: got tr=%b fa=%b expected 0 0", transparent, flash_active);
    end
    pix_valid = 1'b0;
    Reset_n = 1'b1;
    cyc();
    read_pixel(2'd0, 4'd5, mid_v, v, rgb, tr);
    checks++;
    if (mid_v !== 1'b0) begin fails++; $display("[TB] FAIL reset_lookup_early: got %b expected 0", mid_v); end
    checks++;
    if (v !== 1'b1 || rgb !== 12'hF0F || tr !== 1'b1) begin
      fails++; $display("[TB] FAIL reset_lookup: got v=%b rgb=%h tr=%b expected 1 f0f 1", v, rgb, tr);
    end
  endtask

  task automatic test_write_read();
    do_write(2'd2, 4'd3, 12'h815);
    read_pixel(2'd2, 4'd3, mid_v, v, rgb, tr);
    checks++;
    if (mid_v !== 1'b0 || v !== 1'b1) begin fails++; $display("[TB] FAIL wr_latency: got mid=%b v=%b expected 0 1", mid_v, v); end
    checks++;
    if (rgb !== 12'h815 || tr !== 1'b0) begin fails++; $display("[TB] FAIL wr_read: got rgb=%h tr=%b expected 815 0", rgb, tr); end
  endtask

  task automatic test_back_to_back();
    int nvalid;
    logic [11:0] exp_rgb;
    nvalid = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        pix_valid = 1'b1; pix_bank = 2'd2; pix_index = 4'(i);
      end else begin
        pix_valid = 1'b0;
      end
      cyc();
      if (i >= 1 && i <= 16) begin
        if (out_valid === 1'b1) nvalid++;
        exp_rgb = (i - 1 == 3) ? 12'h815 : 12'hF0F;
        checks++;
        if ({red, green, blue} !== exp_rgb) begin
          fails++; $display("[TB] FAIL stream_rgb[%0d]: got %h expected %h", i - 1, {red, green, blue}, exp_rgb);
        end
      end
    end
    checks++;
    if (nvalid != 16) begin fails++; $display("[TB] FAIL stream_count: got %0d expected 16", nvalid); end
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL stream_tail: got %b expected 0", out_valid); end
  endtask

  task automatic test_collision();
    wr_en = 1'b1; wr_bank = 2'd1; wr_index = 4'd7; wr_rgb = 12'hA01;
    pix_valid = 1'b1; pix_bank = 2'd1; pix_index = 4'd7;
    cyc();
    wr_en = 1'b0;
    cyc();
    pix_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || {red, green, blue} !== 12'hF0F) begin
      fails++; $display("[TB] FAIL collide_old: got v=%b rgb=%h expected 1 f0f", out_valid, {red, green, blue});
    end
    cyc();
    checks++;
    if (out_valid !== 1'b1 || {red, green, blue} !== 12'hA01 || transparent !== 1'b0) begin
      fails++; $display("[TB] FAIL collide_new: got v=%b rgb=%h tr=%b expected 1 a01 0", out_valid, {red, green, blue}, transparent);
    end
  endtask

  task automatic test_out_of_range();
    do_write(2'd3, 4'd0, 12'h123);
    read_pixel(2'd3, 4'd0, mid_v, v, rgb, tr);
    checks++;
    if (v !== 1'b1 || rgb !== 12'hF0F || tr !== 1'b1) begin
      fails++; $display("[TB] FAIL oor_read: got v=%b rgb=%h tr=%b expected 1 f0f 1", v, rgb, tr);
    end
    read_pixel(2'd0, 4'd0, mid_v, v, rgb, tr);
    checks++;
    if (rgb !== 12'hF0F) begin fails++; $display("[TB] FAIL oor_alias: got %h expected f0f", rgb); end
  endtask

  task automatic test_flash();
    do_write(2'd0, 4'd1, 12'h32B);
    flash_start = 1'b1;
    cyc();
    flash_start = 1'b0;
    checks++;
    if (flash_active !== 1'b1) begin fails++; $display("[TB] FAIL flash_active_start: got %b expected 1", flash_active); end
    read_pixel(2'd0, 4'd1, mid_v, v, rgb, tr);
    checks++;
    if (rgb !== 12'hFFF || tr !== 1'b0) begin fails++; $display("[TB] FAIL flash_on_white: got rgb=%h tr=%b expected fff 0", rgb, tr); end
    read_pixel(2'd0, 4'd0, mid_v, v, rgb, tr);
    checks++;
    if (rgb !== 12'hF0F || tr !== 1'b1) begin fails++; $display("[TB] FAIL flash_on_key: got rgb=%h tr=%b expected f0f 1", rgb, tr); end
    ticks(3);
    read_pixel(2'd0, 4'd1, mid_v, v, rgb, tr);
    checks++;
    if (rgb !== 12'h32B) begin fails++; $display("[TB] FAIL flash_off: got %h expected 32b", rgb); end
    ticks(3);
    read_pixel(2'd0, 4'd1, mid_v, v, rgb, tr);
    checks++;
    if (rgb !== 12'hFFF) begin fails++; $display("[TB] FAIL flash_on_again: got %h expected fff", rgb); end
    ticks(11);
    checks++;
    if (flash_active !== 1'b1) begin fails++; $display("[TB] FAIL flash_tick17: got %b expected 1", flash_active); end
    ticks(1);
    checks++;
    if (flash_active !== 1'b0) begin fails++; $display("[TB] FAIL flash_tick18: got %b expected 0", flash_active); end
    read_pixel(2'd0, 4'd1, mid_v, v, rgb, tr);
    checks++;
    if (rgb !== 12'h32B) begin fails++; $display("[TB] FAIL flash_idle: got %h expected 32b", rgb); end
  endtask

  task automatic test_restart();
    flash_start = 1'b1;
    cyc();
    flash_start = 1'b0;
    ticks(9);
    read_pixel(2'd0, 4'd1, mid_v, v, rgb, tr);
    checks++;
    if (rgb !== 12'h32B) begin fails++; $display("[TB] FAIL restart_pre_off: got %h expected 32b", rgb); end
    flash_start = 1'b1; frame_tick = 1'b1;
    cyc();
    flash_start = 1'b0; frame_tick = 1'b0;
    read_pixel(2'd0, 4'd1, mid_v, v, rgb, tr);
    checks++;
    if (rgb !== 12'hFFF) begin fails++; $display("[TB] FAIL restart_on: got %h expected fff", rgb); end
    ticks(2);
    read_pixel(2'd0, 4'd1, mid_v, v, rgb, tr);
    checks++;
    if (rgb !== 12'hFFF) begin fails++; $display("[TB] FAIL restart_no_advance: got %h expected fff", rgb); end
    ticks(1);
    read_pixel(2'd0, 4'd1, mid_v, v, rgb, tr);
    checks++;
    if (rgb !== 12'h32B) begin fails++; $display("[TB] FAIL restart_off: got %h expected 32b", rgb); end
    ticks(14);
    checks++;
    if (flash_active !== 1'b1) begin fails++; $display("[TB] FAIL restart_tick17: got %b expected 1", flash_active); end
    ticks(1);
    checks++;
    if (flash_active !== 1'b0) begin fails++; $display("[TB] FAIL restart_tick18: got %b expected 0", flash_active); end
  endtask

  task automatic test_async_reset();
    flash_start = 1'b1;
    cyc();
    flash_start = 1'b0;
    pix_valid = 1'b1; pix_bank = 2'd2; pix_index = 4'd3;
    cyc();
    cyc();
    checks++;
    if (out_valid !== 1'b1 || {red, green, blue} !== 12'hFFF || flash_active !== 1'b1) begin
      fails++; $display("[TB] FAIL areset_pre: got v=%b rgb=%h fa=%b expected 1 fff 1", out_valid, {red, green, blue}, flash_active);
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || {red, green, blue} !== 12'h000 || transparent !== 1'b0 || flash_active !== 1'b0) begin
      fails++; $display("[TB] FAIL areset_immediate: got v=%b rgb=%h tr=%b fa=%b expected 0 000 0 0",
                        out_valid, {red, green, blue}, transparent, flash_active);
    end
    pix_valid = 1'b0;
    cyc();
    cyc();
    Reset_n = 1'b1;
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL areset_no_inflight: got %b expected 0", out_valid); end
    read_pixel(2'd2, 4'd3, mid_v, v, rgb, tr);
    checks++;
    if (v !== 1'b1 || rgb !== 12'hF0F || tr !== 1'b1) begin
      fails++; $display("[TB] FAIL areset_b2i3: got v=%b rgb=%h tr=%b expected 1 f0f 1", v, rgb, tr);
    end
    read_pixel(2'd1, 4'd7, mid_v, v, rgb, tr);
    checks++;
    if (rgb !== 12'hF0F) begin fails++; $display("[TB] FAIL areset_b1i7: got %h expected f0f", rgb); end
    read_pixel(2'd0, 4'd1, mid_v, v, rgb, tr);
    checks++;
    if (rgb !== 12'hF0F || flash_active !== 1'b0) begin
      fails++; $display("[TB] FAIL areset_b0i1: got rgb=%h fa=%b expected f0f 0", rgb, flash_active);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_collision();
    test_out_of_range();
    test_flash();
    test_restart();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
